multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Parametrised multicycle control unit for the ARMv4 subset (DP reg/imm, LDR/STR, B). Replaces
//  the single-cycle decode path. Sequences each instruction through an FSM and holds the NZCV
//  flags. Evaluates the condition field and waits on a memory-ready handshake with optional timeout.
//  Sits between the instruction register and the shared-memory datapath.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: honour mem_ready; 0: memory is single-cycle, mem_ready ignored (treated 1)
//  MEM_TIMEOUT    0  0: wait forever; N>0: abort after N consecutive not-ready cycles
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high
//  Cond        in   4   instr[31:28]
//  Op          in   2   instr[27:26]
//  Funct       in   6   instr[25:20] (I,cmd[3:0],S / L for memory)
//  sh          in   2   shift type instr[6:5]
//  Rd          in   4   destination register
//  ALUFlags    in   4   {N,Z,C,V} from ALU, current cycle
//  mem_ready   in   1   memory access completes this cycle
//  PCWrite     out  1   PC load;  AdrSrc out 1  0=PC 1=ALUResult
//  IRWrite     out  1   IR load;  MemW  out 1  memory write strobe
//  RegW        out  1   register file write
//  ALUSrcA     out  1   0=RD1 1=PC;  ALUSrcB out 2  00=RD2 01=ExtImm 10=const 4
//  ResultSrc   out  2   00=ALUOut 01=Data 10=ALUResult
//  ImmSrc      out  2   = Op;  RegSrc out 3  {Op==01&~L, Op==01, Op==10}
//  ALUControl  out  4   0 ADD 1 SUB 2 AND 3 ORR 4 EOR 5 LSL 6 LSR 7 ASR 8 ROR
//  Flags       out  4   registered NZCV;  state_o out 4  current state code
//  mem_err     out  1   one-cycle pulse on timeout abort;  illegal out 1  pulse, Op==11 in DECODE
// BEHAVIOUR
//  States/codes: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 EXECI7 ALUWB8 BRANCH9.
//  Reset: state=FETCH, Flags=0, wait counter=0, mem_err=illegal=0. While reset is high,
//   PCWrite/IRWrite/MemW/RegW=0 and the muxes hold their FETCH values.
//  FETCH: AdrSrc0 ALUSrcA1 ALUSrcB10 ResultSrc10. IRWrite=PCWrite=mem_ready; stays until ready.
//  DECODE: ALUSrcA1 ALUSrcB10 ResultSrc10. Op01->MEMADR; Op00&~I->EXECR; Op00&I->EXECI;
//   Op10->BRANCH; Op11->FETCH, illegal=1.
//  MEMADR: ALUSrcA0 ALUSrcB01 ADD. Goes to MEMRD if L=Funct[0], else to MEMWR.
//  MEMRD: AdrSrc1, wait for ready, then MEMWB. MEMWB: ResultSrc01, RegW=CondEx, PCWrite=CondEx&Rd==15.
//  MEMWR: AdrSrc1, MemW=CondEx, held stable until the ready cycle; then FETCH.
//  EXECR: ALUSrcA0 ALUSrcB00. EXECI: ALUSrcA0 ALUSrcB01. Both go to ALUWB.
//  ALUWB: ResultSrc00, RegW=CondEx&~NoWrite, PCWrite=that&Rd==15, then FETCH.
//  BRANCH: ALUSrcA0 ALUSrcB01 ADD ResultSrc10, PCWrite=CondEx, then FETCH.
//  ALU decode (EXEC states): cmd 0100 ADD, 0010 SUB, 1010 CMP (SUB, NoWrite), 0000 AND, 1100 ORR.
//   0001 EOR; 1101 MOV maps by sh: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Others: ADD, NoWrite.
//   All other states use ADD.
//  FlagW: CMP=11; S with ADD/SUB=11; S with logic/MOV=10; else 00. FlagW[1]->N,Z; [0]->C,V.
//   Flags are latched from ALUFlags at the end of EXECR/EXECI when CondEx.
//  CondEx uses the registered Flags. Codes 0000-1101 follow the ARM table (EQ..LE).
//   1110 AL=1; 1111 treated as never (0). CondEx=0 suppresses RegW, MemW, PCWrite(non-fetch), flags.
//  Timeout (MEM_HANDSHAKE=1, MEM_TIMEOUT=N>0): counter increments per not-ready cycle in
//   FETCH/MEMRD/MEMWR and clears on ready or on a state change. Reaching N: mem_err pulses, go to FETCH
//   with no write strobes that cycle, counter cleared. Width $clog2(N+1).
//  Reset mid-instruction aborts immediately to FETCH. A mid-instruction abort does not change Flags.
// TESTING
//  ADDS R1,R2,R3 (Cond=1110, ALUFlags=0100), ready=1 -> FETCH,DECODE,EXECR,ALUWB; RegW@ALUWB; Flags=0100.
//  LDR with mem_ready low 3 cycles in MEMRD, MEM_TIMEOUT=0 -> 3 stall cycles, then MEMWB with RegW=1.
//  BEQ with Flags.Z=0 -> BRANCH with PCWrite=0; with Z=1 -> PCWrite=1 for exactly 1 cycle.
//  STR with MEM_TIMEOUT=4 and ready held low -> MemW high for 4 cycles, mem_err pulse, state=FETCH.
//  MOV R15,R2 (sh=00, ALUControl=5) -> PCWrite=RegW=1 in ALUWB. Op=11 -> illegal pulse, back to FETCH.
//  reset asserted in MEMWR -> MemW drops asynchronously; state_o=0, Flags=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARMv4-subset control unit with NZCV flags and memory-ready timeout
//
// Sequences DP reg/imm, LDR/STR and B instructions through a ten-state FSM,
// evaluates the condition field against the registered flags, and waits on a
// memory-ready handshake with an optional abort after MEM_TIMEOUT stall cycles.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   Cond, Op, Funct, sh, Rd instruction fields from the instruction register
//   ALUFlags                {N,Z,C,V} produced by the ALU this cycle
//   mem_ready               memory access completes this cycle
//   PCWrite, IRWrite        PC / IR load enables
//   MemW, RegW              memory write strobe / register file write
//   AdrSrc, ALUSrcA/B       address and ALU operand selects
//   ResultSrc               result bus select
//   ImmSrc, RegSrc          immediate-extend and register-address selects
//   ALUControl              ALU operation code
//   Flags, state_o          registered NZCV, current state code
//   mem_err, illegal        one-cycle pulses: timeout abort, undefined opcode
module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [1:0] sh,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemW,
    output logic       RegW,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] state_o,
    output logic       mem_err,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_EOR = 4'd4;
    localparam logic [3:0] ALU_LSL = 4'd5;
    localparam logic [3:0] ALU_LSR = 4'd6;
    localparam logic [3:0] ALU_ASR = 4'd7;
    localparam logic [3:0] ALU_ROR = 4'd8;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [3:0]    flags_q, flags_d;

    logic       ready;
    logic       waiting;
    logic       timeout;
    logic       cond_ex;
    logic [3:0] alu_ctl;
    logic       no_write;
    logic [1:0] flag_w;
    logic       is_arith;
    logic       is_logic;
    logic       pc_w, ir_w, mem_w, reg_w, err_p, ill_p;
    logic       wb_en;

    assign ready   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // The abort cycle is the one after N stalled cycles have been counted.
    assign timeout = (MEM_HANDSHAKE != 0) && (MEM_TIMEOUT > 0) && waiting
                     && (wait_q == CW'(MEM_TIMEOUT));

    // Condition evaluation against the registered flags.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing decode: cmd = Funct[4:1], S = Funct[0].
    always_comb begin
        alu_ctl  = ALU_ADD;
        no_write = 1'b0;
        is_arith = 1'b0;
        is_logic = 1'b0;
        case (Funct[4:1])
            4'b0100: begin alu_ctl = ALU_ADD; is_arith = 1'b1; end
            4'b0010: begin alu_ctl = ALU_SUB; is_arith = 1'b1; end
            4'b1010: begin alu_ctl = ALU_SUB; no_write = 1'b1; end
            4'b0000: begin alu_ctl = ALU_AND; is_logic = 1'b1; end
            4'b1100: begin alu_ctl = ALU_ORR; is_logic = 1'b1; end
            4'b0001: begin alu_ctl = ALU_EOR; is_logic = 1'b1; end
            4'b1101: begin
                is_logic = 1'b1;
                case (sh)
                    2'b00:   alu_ctl = ALU_LSL;
                    2'b01:   alu_ctl = ALU_LSR;
                    2'b10:   alu_ctl = ALU_ASR;
                    default: alu_ctl = ALU_ROR;
                endcase
            end
            default: begin alu_ctl = ALU_ADD; no_write = 1'b1; end
        endcase

        // CMP always updates all four flags, S bit or not.
        if (Funct[4:1] == 4'b1010)     flag_w = 2'b11;
        else if (Funct[0] && is_arith) flag_w = 2'b11;
        else if (Funct[0] && is_logic) flag_w = 2'b10;
        else                           flag_w = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        err_p      = 1'b0;
        ill_p      = 1'b0;
        wb_en      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ALUControl = ALU_ADD;
        case (state_q)
            FETCH: begin
                if (timeout) begin
                    err_p = 1'b1;
                end else if (ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: begin state_d = FETCH; ill_p = 1'b1; end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (timeout) begin
                    err_p   = 1'b1;
                    state_d = FETCH;
                end else if (ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = cond_ex;
                pc_w      = cond_ex && (Rd == 4'hF);
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                if (timeout) begin
                    err_p   = 1'b1;
                    state_d = FETCH;
                end else begin
                    // Strobe held for the whole access, not just the ready cycle.
                    mem_w = cond_ex;
                    if (ready) state_d = FETCH;
                end
            end
            EXECR, EXECI: begin
                ALUSrcA    = 1'b0;
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_ctl;
                if (cond_ex) begin
                    if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
                    if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
                end
                state_d = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                wb_en     = cond_ex && !no_write;
                reg_w     = wb_en;
                pc_w      = wb_en && (Rd == 4'hF);
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_w      = cond_ex;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Stall counter only advances while parked in a wait state; any progress clears it.
    always_comb begin
        wait_d = '0;
        if ((MEM_TIMEOUT > 0) && waiting && !ready && !timeout)
            wait_d = wait_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flags_q <= flags_d;
        end
    end

    // Strobes are gated by reset so they drop as soon as reset rises.
    assign PCWrite = pc_w  & ~reset;
    assign IRWrite = ir_w  & ~reset;
    assign MemW    = mem_w & ~reset;
    assign RegW    = reg_w & ~reset;
    assign mem_err = err_p & ~reset;
    assign illegal = ill_p & ~reset;

    assign ImmSrc  = Op;
    assign RegSrc  = {(Op == 2'b01) && !Funct[0], Op == 2'b01, Op == 2'b10};
    assign Flags   = flags_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam int TO = 4;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [1:0] sh;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemW, RegW, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] RegSrc;
    logic [3:0] ALUControl, Flags, state_o;
    logic       mem_err, illegal;

    multicycle_controller #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .sh(sh), .Rd(Rd),
        .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemW(MemW), .RegW(RegW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .state_o(state_o), .mem_err(mem_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] mflags = 4'b0000;
    logic [3:0] m_ctl  = 4'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {NoWrite, FlagW[1:0], ALUControl[3:0]}.
    function automatic logic [6:0] alu_model(input logic [3:0] cmd, input logic s, input logic [1:0] shv);
        logic [3:0] ctl;
        logic       nw, arith, lgc;
        logic [1:0] fw;
        ctl = 4'd0; nw = 1'b0; arith = 1'b0; lgc = 1'b0;
        case (cmd)
            4'b0100: begin ctl = 4'd0; arith = 1'b1; end
            4'b0010: begin ctl = 4'd1; arith = 1'b1; end
            4'b1010: begin ctl = 4'd1; nw = 1'b1; end
            4'b0000: begin ctl = 4'd2; lgc = 1'b1; end
            4'b1100: begin ctl = 4'd3; lgc = 1'b1; end
            4'b0001: begin ctl = 4'd4; lgc = 1'b1; end
            4'b1101: begin ctl = 4'd5 + {2'b00, shv}; lgc = 1'b1; end
            default: nw = 1'b1;
        endcase
        fw = (cmd == 4'b1010) ? 2'b11 : (s && arith) ? 2'b11 : (s && lgc) ? 2'b10 : 2'b00;
        return {nw, fw, ctl};
    endfunction

    // Returns {mask, expected} over {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}.
    function automatic logic [19:0] mux_model(input logic [3:0] st, input logic [3:0] ctl);
        logic [9:0] e, m;
        e = 10'd0;
        m = 10'b00_00_00_1111;
        case (st)
            S_FETCH:  begin e = {1'b0, 1'b1, 2'b10, 2'b10, 4'd0}; m = 10'b11_11_11_1111; end
            S_DECODE: begin e = {1'b0, 1'b1, 2'b10, 2'b10, 4'd0}; m = 10'b01_11_11_1111; end
            S_MEMADR: begin e = {1'b0, 1'b0, 2'b01, 2'b00, 4'd0}; m = 10'b01_11_00_1111; end
            S_MEMRD:  begin e = {1'b1, 9'd0};                     m = 10'b10_00_00_1111; end
            S_MEMWB:  begin e = {2'b00, 2'b00, 2'b01, 4'd0};      m = 10'b00_00_11_1111; end
            S_MEMWR:  begin e = {1'b1, 9'd0};                     m = 10'b10_00_00_1111; end
            S_EXECR:  begin e = {1'b0, 1'b0, 2'b00, 2'b00, ctl};  m = 10'b01_11_00_1111; end
            S_EXECI:  begin e = {1'b0, 1'b0, 2'b01, 2'b00, ctl};  m = 10'b01_11_00_1111; end
            S_ALUWB:  begin e = 10'd0;                            m = 10'b00_00_11_1111; end
            S_BRANCH: begin e = {1'b0, 1'b0, 2'b01, 2'b10, 4'd0}; m = 10'b01_11_11_1111; end
            default:  begin e = 10'd0; m = 10'd0; end
        endcase
        return {m, e & m};
    endfunction

    // One clock cycle: inputs already driven, sample at negedge, return at posedge+1.
    task automatic cycle(input string nm, input logic [3:0] st, input logic [5:0] sb);
        logic [19:0] me;
        @(negedge clk);
        me = mux_model(st, m_ctl);
        chk({nm, ":state"}, 16'(state_o), 16'(st));
        chk({nm, ":strobes"}, 16'({PCWrite, IRWrite, MemW, RegW, mem_err, illegal}), 16'(sb));
        chk({nm, ":mux"}, 16'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} & me[19:10]), 16'(me[9:0]));
        chk({nm, ":flags"}, 16'(Flags), 16'(mflags));
        @(posedge clk);
        #1;
    endtask

    // Memory wait state: ready after `stall` low cycles, abort once TO low cycles have elapsed.
    task automatic wait_state(input string nm, input logic [3:0] st, input int stall,
                              input logic [5:0] sb_wait, input logic [5:0] sb_ready, output logic done);
        done = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            if (k == TO) begin
                mem_ready = 1'b0;
                cycle({nm, "/abort"}, st, 6'b000010);
                return;
            end
            mem_ready = (k >= stall);
            cycle(nm, st, mem_ready ? sb_ready : sb_wait);
            if (mem_ready) begin
                done = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input string nm, input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [1:0] s, input logic [3:0] r, input logic [3:0] af,
                             input int fst, input int mst);
        logic       ce, ok, wb;
        logic [6:0] al;
        Cond = c; Op = o; Funct = f; sh = s; Rd = r; ALUFlags = af;
        ce = cond_ok(c, mflags);
        al = alu_model(f[4:1], f[0], s);
        m_ctl = 4'd0;
        wait_state({nm, "/fetch"}, S_FETCH, fst, 6'b000000, 6'b110000, ok);
        if (!ok) return;
        chk({nm, ":src"}, 16'({ImmSrc, RegSrc}), 16'({o, (o == 2'b01) && !f[0], o == 2'b01, o == 2'b10}));
        mem_ready = 1'($urandom);
        cycle({nm, "/decode"}, S_DECODE, (o == 2'b11) ? 6'b000001 : 6'b000000);
        case (o)
            2'b01: begin
                mem_ready = 1'($urandom);
                cycle({nm, "/memadr"}, S_MEMADR, 6'b000000);
                if (f[0]) begin
                    wait_state({nm, "/memrd"}, S_MEMRD, mst, 6'b000000, 6'b000000, ok);
                    if (ok) begin
                        mem_ready = 1'($urandom);
                        cycle({nm, "/memwb"}, S_MEMWB, {ce && (r == 4'hF), 2'b00, ce, 2'b00});
                    end
                end else begin
                    wait_state({nm, "/memwr"}, S_MEMWR, mst, {2'b00, ce, 3'b000}, {2'b00, ce, 3'b000}, ok);
                end
            end
            2'b00: begin
                mem_ready = 1'($urandom);
                m_ctl = al[3:0];
                cycle({nm, "/exec"}, f[5] ? S_EXECI : S_EXECR, 6'b000000);
                m_ctl = 4'd0;
                if (ce) begin
                    if (al[5]) mflags[3:2] = af[3:2];
                    if (al[4]) mflags[1:0] = af[1:0];
                end
                // Writeback evaluates the condition against the freshly latched flags.
                wb = cond_ok(c, mflags) && !al[6];
                mem_ready = 1'($urandom);
                cycle({nm, "/aluwb"}, S_ALUWB, {wb && (r == 4'hF), 2'b00, wb, 2'b00});
            end
            2'b10: begin
                mem_ready = 1'($urandom);
                cycle({nm, "/branch"}, S_BRANCH, {ce, 5'b00000});
            end
            default: ;
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b1;
        Cond = 4'h0; Op = 2'b00; Funct = 6'd0; sh = 2'b00; Rd = 4'd0; ALUFlags = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset:state", 16'(state_o), 16'(S_FETCH));
        chk("reset:strobes", 16'({PCWrite, IRWrite, MemW, RegW, mem_err, illegal}), 16'd0);
        chk("reset:flags", 16'(Flags), 16'd0);
        chk("reset:mux", 16'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}), 16'({1'b0, 1'b1, 2'b10, 2'b10, 4'd0}));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("adds",      4'hE, 2'b00, 6'b001001, 2'b00, 4'd1,  4'b0100, 0, 0);
        chk("adds:flags", 16'(Flags), 16'h0004);
        run_instr("ldr_stall", 4'hE, 2'b01, 6'b011001, 2'b00, 4'd3,  4'b0000, 0, 3);
        run_instr("beq_taken", 4'h0, 2'b10, 6'b100000, 2'b00, 4'd0,  4'b0000, 1, 0);
        run_instr("adds_zero", 4'hE, 2'b00, 6'b001001, 2'b00, 4'd1,  4'b0000, 0, 0);
        run_instr("beq_not",   4'h0, 2'b10, 6'b100000, 2'b00, 4'd0,  4'b0000, 0, 0);
        run_instr("str_tmo",   4'hE, 2'b01, 6'b011000, 2'b00, 4'd2,  4'b0000, 0, 99);
        run_instr("mov_pc",    4'hE, 2'b00, 6'b011010, 2'b00, 4'hF,  4'b0000, 0, 0);
        run_instr("op11",      4'hE, 2'b11, 6'b000000, 2'b00, 4'd0,  4'b0000, 0, 0);
        run_instr("fetch_tmo", 4'hE, 2'b00, 6'b001001, 2'b00, 4'd1,  4'b1111, 99, 0);
        run_instr("cmp",       4'hE, 2'b00, 6'b010101, 2'b00, 4'd0,  4'b1011, 0, 0);
        run_instr("nv_add",    4'hF, 2'b00, 6'b001001, 2'b00, 4'hF,  4'b0000, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] o;
            logic [3:0] c, r;
            int         fs, ms;
            o  = 2'($urandom);
            c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            r  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            fs = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 2));
            ms = ($urandom_range(0, 4) == 0) ? 99 : int'($urandom_range(0, 3));
            run_instr("rnd", c, o, 6'($urandom), 2'($urandom), r, 4'($urandom), fs, ms);
        end

        // Reset in the middle of a store.
        run_instr("cmp_all", 4'hE, 2'b00, 6'b010101, 2'b00, 4'd0, 4'hF, 0, 0);
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        m_ctl = 4'd0;
        mem_ready = 1'b1;
        cycle("rst/fetch", S_FETCH, 6'b110000);
        cycle("rst/decode", S_DECODE, 6'b000000);
        cycle("rst/memadr", S_MEMADR, 6'b000000);
        mem_ready = 1'b0;
        #2;
        chk("rst:memw_before", 16'(MemW), 16'd1);
        reset = 1'b1;
        #1;
        mflags = 4'b0000;
        chk("rst:memw_async", 16'(MemW), 16'd0);
        chk("rst:state", 16'(state_o), 16'(S_FETCH));
        chk("rst:flags", 16'(Flags), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr("post_rst", 4'hE, 2'b00, 6'b101001, 2'b00, 4'd4, 4'b1000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
